pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/pipe_watchdog.sv | 25 ++
 rtl/pipeline_ctrl.sv | 89 ++++++++
 tb/tb_pipeline_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for pipeline_ctrl: stall bit layout, stall patterns, FSM encoding, default vector.
// The watchdog feature is enabled by defining PIPE_WATCHDOG_EN.
package pipeline_ctrl_pkg;

    localparam int STALL_W   = 6;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    // A stalled stage also holds every stage upstream of it.
    localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
    localparam logic [STALL_W-1:0] STALL_BY_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_BY_EX   = 6'b001111;
    localparam logic [STALL_W-1:0] STALL_BY_MEM  = 6'b011111;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_watchdog.sv
// Counts consecutive enabled cycles and flags the cycle in which the count reaches LIMIT.
// Only instantiated when PIPE_WATCHDOG_EN is defined.
module pipe_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    output logic hit
);

    logic [15:0] count;

    // hit fires on the enabled cycle whose increment would land on LIMIT.
    assign hit = count_en && (({1'b0, count} + 17'd1) == 17'(LIMIT));

    always_ff @(posedge clk) begin
        if (rst || !count_en || hit) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/exception controller: priority stall vector, one-cycle flush FSM, stall counter.
// Optional MEM-stall watchdog is built when PIPE_WATCHDOG_EN is defined.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int unsigned WDT_LIMIT  = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_request_id,
    input  logic               stall_request_ex,
    input  logic               stall_request_mem,
    input  logic               exception_flag,
    input  logic               eret_flag,
    input  logic [31:0]        cp0_epc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        flush_pc,
    output logic               watchdog_timeout,
    output logic [31:0]        stall_cycle_count
);

    state_t state;
    logic   run;
    logic   timeout_hit;

    assign run = (state == ST_RUN);

    if (WDT_LIMIT < 1 || WDT_LIMIT > 65535) begin : g_limit_check
        $error("pipeline_ctrl: WDT_LIMIT must be in 1..65535");
    end

`ifdef PIPE_WATCHDOG_EN
    pipe_watchdog #(.LIMIT(WDT_LIMIT)) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .count_en (run && stall_request_mem),
        .hit      (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    // An exception in RUN suppresses stalls so the faulting instruction commits the flush.
    always_comb begin
        stall = STALL_NONE;
        if (!rst && run && !exception_flag) begin
            if (stall_request_mem)     stall = STALL_BY_MEM;
            else if (stall_request_ex) stall = STALL_BY_EX;
            else if (stall_request_id) stall = STALL_BY_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= ST_RUN;
            flush             <= 1'b0;
            flush_pc          <= '0;
            watchdog_timeout  <= 1'b0;
            stall_cycle_count <= '0;
        end else begin
            watchdog_timeout <= timeout_hit;
            if (stall[STALL_PC] && stall_cycle_count != 32'hFFFF_FFFF) begin
                stall_cycle_count <= stall_cycle_count + 32'd1;
            end
            case (state)
                ST_RUN: begin
                    if (exception_flag || timeout_hit) begin
                        state    <= ST_FLUSH;
                        flush    <= 1'b1;
                        flush_pc <= (exception_flag && eret_flag) ? cp0_epc : EXC_VECTOR;
                    end else begin
                        flush <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
                default: begin
                    state <= ST_RUN;
                    flush <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: event-level model compared every cycle plus directed literals.
// Watchdog scenarios follow PIPE_WATCHDOG_EN as seen by this compilation.
module tb_pipeline_ctrl;

    localparam logic [31:0] EXC = 32'hBFC0_0380;
    localparam int LIMIT = 4;
`ifdef PIPE_WATCHDOG_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
    logic        exc = 1'b0, eret = 1'b0;
    logic [31:0] epc = '0;
    logic [5:0]  stall;
    logic        flush, wdt;
    logic [31:0] flush_pc, count;

    int passes = 0;
    int total  = 0;
    bit cmp_on = 1'b0;
    bit preload_pending = 1'b0;

    pipeline_ctrl #(.EXC_VECTOR(EXC), .WDT_LIMIT(LIMIT)) dut (
        .clk               (clk),
        .rst               (rst),
        .stall_request_id  (req_id),
        .stall_request_ex  (req_ex),
        .stall_request_mem (req_mem),
        .exception_flag    (exc),
        .eret_flag         (eret),
        .cp0_epc           (epc),
        .stall             (stall),
        .flush             (flush),
        .flush_pc          (flush_pc),
        .watchdog_timeout  (wdt),
        .stall_cycle_count (count)
    );

    always #5 clk = ~clk;

    // Model: "currently flushing", redirect target, pending timeout pulse, cycle count, MEM-stall run length.
    logic        m_flush = 1'b0;
    logic [31:0] m_pc = '0;
    logic        m_wdt = 1'b0;
    logic [31:0] m_count = '0;
    int          m_run = 0;

    function automatic logic [5:0] exp_stall();
        if (rst || m_flush || exc) return 6'b000000;
        if (req_mem) return 6'b011111;
        if (req_ex)  return 6'b001111;
        if (req_id)  return 6'b000111;
        return 6'b000000;
    endfunction

    function automatic bit wdt_fire();
        return WDT_ON && !m_flush && req_mem && (m_run + 1 == LIMIT);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c, input bit stalled);
        if (!stalled || c == 32'hFFFF_FFFF) return c;
        return c + 32'd1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_flush <= 1'b0;
            m_pc    <= '0;
            m_wdt   <= 1'b0;
            m_count <= '0;
            m_run   <= 0;
        end else begin
            m_count <= sat_inc(preload_pending ? 32'hFFFF_FFFE : m_count, exp_stall() != 6'b0);
            m_wdt   <= wdt_fire();
            m_run   <= (!m_flush && req_mem && !wdt_fire()) ? m_run + 1 : 0;
            m_flush <= !m_flush && (exc || wdt_fire());
            if (!m_flush && (exc || wdt_fire()))
                m_pc <= (exc && eret) ? epc : EXC;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("stall", {26'b0, stall}, {26'b0, exp_stall()});
            chk("flush", {31'b0, flush}, {31'b0, m_flush});
            if (m_flush) chk("flush_pc", flush_pc, m_pc);
            chk("watchdog_timeout", {31'b0, wdt}, {31'b0, m_wdt});
            chk("stall_cycle_count", count, m_count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic i, input logic e, input logic m,
                          input logic x, input logic r, input logic [31:0] p);
        req_id = i; req_ex = e; req_mem = m; exc = x; eret = r; epc = p;
    endtask

    initial begin
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        cmp_on = 1'b1;
        #1;
        chk("lit_reset_stall", {26'b0, stall}, 32'd0);
        tick();
        chk("lit_reset_count", count, 32'd0);
        chk("lit_reset_flush", {31'b0, flush}, 32'd0);
        chk("lit_reset_pc", flush_pc, 32'd0);
        rst = 1'b0;

        // stall priority
        set_in(1, 0, 0, 0, 0, 0); #1;
        chk("lit_stall_id", {26'b0, stall}, 32'b000111);
        tick();
        set_in(1, 1, 0, 0, 0, 0); #1;
        chk("lit_stall_ex", {26'b0, stall}, 32'b001111);
        tick();
        set_in(1, 1, 1, 0, 0, 0); #1;
        chk("lit_stall_mem", {26'b0, stall}, 32'b011111);
        tick();
        set_in(0, 0, 0, 0, 0, 0); #1;
        chk("lit_count3", count, 32'd3);
        tick();

        // exception beats a MEM stall
        set_in(0, 0, 1, 1, 0, 0); #1;
        chk("lit_exc_stall0", {26'b0, stall}, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_exc_flush", {31'b0, flush}, 32'd1);
        chk("lit_exc_pc", flush_pc, EXC);
        tick();
        chk("lit_exc_done", {31'b0, flush}, 32'd0);

        // ERET, then a second exception inside the flush cycle is ignored
        set_in(1, 0, 0, 1, 1, 32'h8000_1234);
        tick();
        set_in(1, 0, 1, 1, 0, 32'h1111_2222);
        chk("lit_eret_flush", {31'b0, flush}, 32'd1);
        chk("lit_eret_pc", flush_pc, 32'h8000_1234);
        #1;
        chk("lit_flush_stall0", {26'b0, stall}, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_no_second_flush", {31'b0, flush}, 32'd0);
        tick();

        // reset during FLUSH
        set_in(0, 0, 0, 1, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        chk("lit_pre_rst_flush", {31'b0, flush}, 32'd1);
        tick();
        chk("lit_rst_flush", {31'b0, flush}, 32'd0);
        chk("lit_rst_count", count, 32'd0);
        rst = 1'b0;
        tick();
        set_in(0, 0, 0, 1, 1, 32'h0000_4000);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_run_after_rst", {31'b0, flush}, 32'd1);
        chk("lit_run_after_rst_pc", flush_pc, 32'h0000_4000);
        tick();

        // watchdog
        set_in(0, 0, 1, 0, 0, 0);
        repeat (3) tick();
        chk("lit_wdt_early", {31'b0, wdt}, 32'd0);
        tick();
        set_in(0, 0, 0, 0, 0, 0);
        chk("lit_wdt_pulse", {31'b0, wdt}, {31'b0, WDT_ON});
        chk("lit_wdt_flush", {31'b0, flush}, {31'b0, WDT_ON});
        if (WDT_ON) chk("lit_wdt_pc", flush_pc, EXC);
        tick();
        chk("lit_wdt_once", {31'b0, wdt}, 32'd0);
        set_in(0, 0, 1, 0, 0, 0);
        repeat (3) tick();
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) begin
            tick();
            chk("lit_wdt_short", {31'b0, wdt}, 32'd0);
            chk("lit_wdt_short_flush", {31'b0, flush}, 32'd0);
        end

        // saturation from a forced preload
        cmp_on = 1'b0;
        force dut.stall_cycle_count = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cycle_count;
        preload_pending = 1'b1;
        set_in(1, 0, 0, 0, 0, 0);
        tick();
        preload_pending = 1'b0;
        cmp_on = 1'b1;
        chk("lit_sat_first", count, 32'hFFFF_FFFF);
        repeat (2) tick();
        chk("lit_sat_hold", count, 32'hFFFF_FFFF);
        set_in(0, 0, 0, 0, 0, 0);
        repeat (2) tick();

        cmp_on = 1'b0;
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
